rv_timer_cmp_sched: RTL and testbench

- Time-multiplexes one 64-bit `mtime >= mtimecmp` comparator across N hart compare registers and holds per-hart interrupt state.
- Owns the mtimecmp register bank, written over a 32-bit half-word port from the register interface.
- Sits between the register file and the timer core. Replaces N parallel 64-bit comparators with a round-robin scan plus priority re-evaluation of freshly written entries.

---
 rtl/rv_timer_cmp_sched.sv | 118 +++++++++++
 tb/tb_rv_timer_cmp_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_timer_cmp_sched.sv
// Shared mtime >= mtimecmp comparator for N harts: round-robin scan with
// priority re-evaluation of freshly written (dirty) entries.
module rv_timer_cmp_sched #(
  parameter  int N    = 4,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            active,
  input  logic [63:0]     mtime,
  input  logic            cmp_we,
  input  logic [IDXW-1:0] cmp_idx,
  input  logic            cmp_hi,
  input  logic [31:0]     cmp_wdata,
  input  logic [IDXW-1:0] rd_idx,
  input  logic            rd_hi,
  output logic [31:0]     rd_data,
  output logic [N-1:0]    intr,
  output logic            sweep_done
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e          state_q, state_d;
  logic [63:0]     cmp_q [N];
  logic [N-1:0]    intr_q, intr_d, dirty_q, dirty_d;
  logic [IDXW-1:0] ptr_q, ptr_d, dirty_sel, sel;
  logic            sweep_q, sweep_d, any_dirty, hit, wr_ok, ptr_last;

  assign wr_ok    = cmp_we && (32'(cmp_idx) < 32'(N));
  assign ptr_last = (ptr_q == IDXW'(N - 1));

  // Lowest-index dirty entry takes the comparator ahead of the scan pointer.
  always_comb begin
    dirty_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dirty_q[i]) dirty_sel = IDXW'(i);
    end
    any_dirty = |dirty_q;
    sel       = any_dirty ? dirty_sel : ptr_q;
    hit       = (mtime >= cmp_q[sel]);
  end

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    dirty_d = dirty_q;
    ptr_d   = ptr_q;
    sweep_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        intr_d = '0;
        ptr_d  = '0;
        if (active) begin
          state_d = SCAN;
          dirty_d = '1;
        end
      end
      SCAN: begin
        if (!active) begin
          state_d = IDLE;
          intr_d  = '0;
          ptr_d   = '0;
          dirty_d = '0;
        end else begin
          intr_d[sel]  = hit;
          dirty_d[sel] = 1'b0;
          if (!any_dirty) begin
            ptr_d   = ptr_last ? '0 : ptr_q + 1'b1;
            sweep_d = ptr_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A write overrides any same-cycle evaluation of that entry.
    if (wr_ok) begin
      intr_d[cmp_idx]  = 1'b0;
      dirty_d[cmp_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      intr_q  <= '0;
      dirty_q <= '0;
      ptr_q   <= '0;
      sweep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      dirty_q <= dirty_d;
      ptr_q   <= ptr_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q <= '{default: '1};
    end else if (wr_ok) begin
      if (cmp_hi) cmp_q[cmp_idx][63:32] <= cmp_wdata;
      else        cmp_q[cmp_idx][31:0]  <= cmp_wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IDXW'(i)) rd_data = rd_hi ? cmp_q[i][63:32] : cmp_q[i][31:0];
    end
  end

  assign intr       = intr_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_rv_timer_cmp_sched.sv
// Bench for rv_timer_cmp_sched: directed scenarios then random traffic,
// all checked each cycle against a rule-level reference model.
module tb_rv_timer_cmp_sched;
  localparam int N    = 4;
  localparam int IDXW = 2;

  logic            clk_i = 1'b0, rst_ni = 1'b0, active = 1'b0;
  logic [63:0]     mtime = '0;
  logic            cmp_we = 1'b0, cmp_hi = 1'b0, rd_hi = 1'b0;
  logic [IDXW-1:0] cmp_idx = '0, rd_idx = '0;
  logic [31:0]     cmp_wdata = '0;
  logic [31:0]     rd_data;
  logic [N-1:0]    intr;
  logic            sweep_done;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  longint unsigned m_cmp [N];
  bit              m_dirty [N];
  logic [N-1:0]    m_intr;
  int              m_ptr;
  bit              m_scan, m_sweep;

  always #5 clk_i = ~clk_i;

  rv_timer_cmp_sched #(.N(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .active(active), .mtime(mtime),
    .cmp_we(cmp_we), .cmp_idx(cmp_idx), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
    .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data),
    .intr(intr), .sweep_done(sweep_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_dirty[i] = 1'b0;
    end
    m_intr = '0; m_ptr = 0; m_scan = 1'b0; m_sweep = 1'b0;
  endfunction

  function automatic void model_step();
    int sel = -1;
    int w   = int'(cmp_idx);
    m_sweep = 1'b0;
    if (!m_scan) begin
      m_intr = '0; m_ptr = 0;
      if (active) begin
        m_scan = 1'b1;
        for (int i = 0; i < N; i++) m_dirty[i] = 1'b1;
      end
    end else if (!active) begin
      m_scan = 1'b0; m_intr = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_dirty[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) if (m_dirty[i] && sel < 0) sel = i;
      if (sel < 0) begin
        sel     = m_ptr;
        m_ptr   = (m_ptr + 1) % N;
        m_sweep = (m_ptr == 0);
      end
      m_intr[sel]  = (mtime >= m_cmp[sel]);
      m_dirty[sel] = 1'b0;
    end
    if (cmp_we && w < N) begin
      if (cmp_hi) m_cmp[w] = (longint'(cmp_wdata) << 32) | (m_cmp[w] & 64'h0000_0000_FFFF_FFFF);
      else        m_cmp[w] = (m_cmp[w] & 64'hFFFF_FFFF_0000_0000) | longint'(cmp_wdata);
      m_intr[w]  = 1'b0;
      m_dirty[w] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] rd_model();
    if (int'(rd_idx) >= N) return '0;
    return rd_hi ? 32'(m_cmp[rd_idx] >> 32) : 32'(m_cmp[rd_idx]);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    if (rst_ni) model_step(); else model_reset();
    @(negedge clk_i);
    chk("intr", intr, m_intr);
    chk("sweep_done", sweep_done, m_sweep);
    chk("rd_data", rd_data, rd_model());
  endtask

  task automatic wr(input int idx, input bit hi, input logic [31:0] d);
    cmp_we = 1'b1; cmp_idx = IDXW'(idx); cmp_hi = hi; cmp_wdata = d;
    tick();
    cmp_we = 1'b0;
  endtask

  initial begin
    int sc, h;
    model_reset();
    active = 1'b1; rd_idx = 2'd2; rd_hi = 1'b1;
    // reset, then idle scan with no interrupts
    repeat (2) tick();
    chk("rst_rd_hi", rd_data, 32'hFFFF_FFFF);
    rst_ni = 1'b1;
    repeat (5) tick();
    sc = 0;
    repeat (16) begin tick(); sc += int'(sweep_done); end
    chk("sweep_count", sc, 4);
    chk("intr_none", intr, 4'b0000);

    // equality asserts, below deasserts
    mtime = 64'h100;
    wr(1, 1'b0, 32'h100);
    wr(1, 1'b1, 32'h0);
    tick();
    chk("eq_hit", intr[1], 1'b1);
    mtime = 64'hFF;
    repeat (6) tick();
    chk("below", intr[1], 1'b0);

    // software clear by writing a larger compare value
    mtime = 64'h100;
    repeat (5) tick();
    chk("re_hit", intr[1], 1'b1);
    mtime = 64'h150;
    wr(1, 1'b0, 32'h200);
    chk("wr_clr", intr[1], 1'b0);
    repeat (6) tick();
    chk("wr_stay", intr[1], 1'b0);
    for (int t = 16'h160; t < 16'h200; t += 16'h10) begin mtime = 64'(t); tick(); end
    mtime = 64'h200;
    repeat (4) tick();
    chk("ramp", intr[1], 1'b1);

    // several dirty entries served in index order
    mtime = 64'd5;
    wr(3, 1'b1, 0); wr(0, 1'b1, 0); wr(2, 1'b1, 0);
    wr(3, 1'b0, 0); wr(0, 1'b0, 0); wr(2, 1'b0, 0);
    repeat (4) tick();
    chk("multi", intr, 4'b1101);

    // collision: write lands on the entry being evaluated
    h = m_ptr;
    wr(h, 1'b0, 32'd1);
    chk("coll_clr", intr[h], 1'b0);
    tick();
    chk("coll_reeval", intr[h], 1'b1);

    // deactivate / reactivate
    mtime = 64'h300;
    wr(2, 1'b1, 32'h1);
    repeat (6) tick();
    chk("pat", intr, 4'b1011);
    active = 1'b0;
    tick();
    chk("idle_clr", intr, 4'b0000);
    repeat (3) tick();
    active = 1'b1;
    repeat (5) tick();
    chk("reactivate", intr, 4'b1011);

    // asynchronous reset mid-scan
    repeat (2) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_intr", intr, 4'b0000);
    chk("arst_sweep", sweep_done, 1'b0);
    model_reset();
    for (int i = 0; i < 2 * N; i++) begin
      rd_idx = IDXW'(i >> 1); rd_hi = i[0];
      #0.1;
      chk("arst_cmp", rd_data, 32'hFFFF_FFFF);
    end
    tick();
    rst_ni = 1'b1;

    // randomized traffic
    repeat (600) begin
      int r = $urandom_range(0, 99);
      if (r < 2)      mtime = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
      else if (r < 4) mtime = 64'($urandom_range(0, 1024));
      else            mtime = mtime + 64'($urandom_range(0, 40));
      active  = ($urandom_range(0, 99) < 95);
      rd_idx  = IDXW'($urandom_range(0, N - 1));
      rd_hi   = 1'($urandom_range(0, 1));
      cmp_we  = ($urandom_range(0, 99) < 30);
      cmp_idx = IDXW'($urandom_range(0, N - 1));
      cmp_hi  = 1'($urandom_range(0, 1));
      if (cmp_hi) cmp_wdata = ($urandom_range(0, 9) == 0) ? $urandom() : mtime[63:32];
      else        cmp_wdata = mtime[31:0] + 32'($urandom_range(0, 200)) - 32'd100;
      tick();
    end
    cmp_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
